simon_engine: RTL and testbench
===============================

Name: simon_engine

Overview:
- Parametrised Simon game sequencer for N buttons/LEDs and a configurable maximum sequence length.
- Grows a pseudo-random sequence one step per round and plays it back on LEDs using tick-timed on/off phases.
- Checks player presses against the stored sequence and reports score, game over and win.
- Sits between the button interpreter and the LED, frequency and display blocks; its num/pressed outputs feed numToLed, numToFrequency and Speaker directly.

Parameters:
- NUM_BTNS, 4: buttons/LEDs (channels), legal 2..8; NW = clog2(NUM_BTNS).
- MAX_LEN, 32: sequence memory depth = winning length; LW = clog2(MAX_LEN+1).
- TICK_DIV, 12500000: clk cycles per tick.
- ON_TICKS, 2: ticks an LED stays lit during playback.
- OFF_TICKS, 1: dark ticks after each playback step and between rounds.
- LFSR_SEED, 16'hACE1: LFSR reset value; must be nonzero.
- TIMEOUT_TICKS, 10: player timeout in ticks; used only with TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- btns  in  NUM_BTNS  debounced, clk-synchronous button levels; valid only when exactly one bit is set.
- simon_turn  out  1  1 while the engine plays the sequence.
- num  out  NW  current button index (engine step or player press).
- pressed  out  1  1 while the indexed LED/tone is active.
- leds  out  NUM_BTNS  one-hot of num when pressed, else 0.
- game_over  out  1  set on a wrong press (or timeout).
- win  out  1  set when MAX_LEN rounds have been completed.
- score  out  LW  rounds completed in the current game.

Behaviour:
- Reset (asynchronous):
  - All outputs 0; LFSR = LFSR_SEED; length = 0; idx = 0; tick counter = 0.
  - State = ADD; reset takes effect immediately in any state, mid-playback included.
- LFSR: 16-bit Galois LFSR, mask 16'hB400, advances every clk cycle regardless of state.
- Sample value: s = lfsr[NW-1:0]; if s >= NUM_BTNS, use s - NUM_BTNS.
- Timed states: tick counter clears on entry. One tick = TICK_DIV clk cycles. Timed durations are exact: ON_TICKS*TICK_DIV cycles for PLAY_ON, OFF_TICKS*TICK_DIV cycles for PLAY_OFF and GAP.
- State machine:
  - ADD (1 cycle): mem[length] <= sample; length++; idx = 0; go to PLAY_ON.
  - PLAY_ON: simon_turn=1, num=mem[idx], pressed=1. After ON_TICKS, go to PLAY_OFF.
  - PLAY_OFF: simon_turn=1, pressed=0. After OFF_TICKS, idx++. If idx == length: idx=0, go to WAIT_IN; else go to PLAY_ON.
  - WAIT_IN:
    - simon_turn=0.
    - If btns is one-hot: num = encoded index, pressed = 1 (mirrors player).
    - On the first cycle btns becomes one-hot after an all-zero cycle: compare to mem[idx]. Match -> WAIT_REL; mismatch -> OVER.
    - btns with 2+ bits set: pressed=0, no compare, stay in WAIT_IN.
  - WAIT_REL:
    - Keep pressed/num while the button is held.
    - On the first cycle btns == 0: idx++.
      - If idx == length: score = length; go to WIN if length == MAX_LEN, else GAP.
      - Else go to WAIT_IN.
  - GAP: pressed=0 for OFF_TICKS, then go to ADD.
  - OVER:
    - game_over=1; pressed=0; score holds.
    - Wait for btns==0, then on any one-hot press clear length, score and game_over, and go to ADD.
  - WIN: win=1; restart the same way as OVER.
- Memory: MAX_LEN x NW registers; never written beyond index MAX_LEN-1.
- Simultaneous events: a press during PLAY_ON or PLAY_OFF is ignored, and an edge is not latched. A button still held on entry to WAIT_IN needs a release before it counts.

Optional Feature:
- Macro: SIMON_TIMEOUT_EN.
- Defined: a tick counter runs in WAIT_IN (cleared on entry and on each accepted press). TIMEOUT_TICKS ticks with no accepted press -> OVER, with game_over=1.
- Undefined: WAIT_IN waits indefinitely; TIMEOUT_TICKS is unused and no timeout logic is synthesised.

Test Plan:
- Bench parameters for all scenarios: NUM_BTNS=4, MAX_LEN=4, TICK_DIV=4, ON_TICKS=2, OFF_TICKS=1.
- Reset release -> after ADD, simon_turn=1, pressed=1 for exactly 8 clk cycles, then 0 for 4 cycles; leds one-hot of mem[0]; then simon_turn=0.
- Player copies mem[0] (press, release) -> score=1, GAP of 4 cycles, then playback of 2 steps totalling 24 cycles.
- Player presses a wrong button in round 2 -> game_over=1 on the compare cycle; score stays 1; further presses give no playback until release followed by a press.
- Player presses btns=4'b0011 in WAIT_IN -> pressed=0, no state change; then 4'b0000 and the correct button -> accepted.
- Correct play through 4 rounds -> win=1, score=4. Assert reset during round-3 playback -> all outputs 0 immediately, new game starts with length 1.
- With SIMON_TIMEOUT_EN and TIMEOUT_TICKS=3: no press for 12 cycles in WAIT_IN -> game_over=1. Without the macro: no timeout after 1000 cycles.

Source files
------------

// File: rtl/simon_engine.sv
// rtl/simon_engine.sv - Simon game sequencer: LFSR-grown sequence, tick-timed playback, player checking.
// Optional player timeout in WAIT_IN is enabled by defining SIMON_TIMEOUT_EN.
`timescale 1ns/1ps
module simon_engine #(
  parameter int          NUM_BTNS      = 4,
  parameter int          MAX_LEN       = 32,
  parameter int          TICK_DIV      = 12500000,
  parameter int          ON_TICKS      = 2,
  parameter int          OFF_TICKS     = 1,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1,
  parameter int          TIMEOUT_TICKS = 10,
  localparam int         NW            = $clog2(NUM_BTNS),
  localparam int         LW            = $clog2(MAX_LEN + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_BTNS-1:0] btns,
  output logic                simon_turn,
  output logic [NW-1:0]       num,
  output logic                pressed,
  output logic [NUM_BTNS-1:0] leds,
  output logic                game_over,
  output logic                win,
  output logic [LW-1:0]       score
);

  localparam int AW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int DW    = $clog2(TICK_DIV + 1);
  localparam int TMAX0 = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int TMAX  = (TMAX0 > TIMEOUT_TICKS) ? TMAX0 : TIMEOUT_TICKS;
  localparam int TW    = $clog2(TMAX + 1);

  localparam logic [DW-1:0] DIV_LAST  = DW'(TICK_DIV - 1);
  localparam logic [TW-1:0] ON_LAST   = TW'(ON_TICKS - 1);
  localparam logic [TW-1:0] OFF_LAST  = TW'(OFF_TICKS - 1);
  localparam logic [LW-1:0] MAX_LEN_V = LW'(MAX_LEN);
  localparam logic [NW:0]   NB_EXT    = (NW + 1)'(NUM_BTNS);
`ifdef SIMON_TIMEOUT_EN
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_TICKS - 1);
`endif

  typedef enum logic [2:0] {
    S_ADD, S_PLAY_ON, S_PLAY_OFF, S_WAIT_IN, S_WAIT_REL, S_GAP, S_OVER, S_WIN
  } state_t;

  state_t        state;
  logic [15:0]   lfsr;
  logic [NW-1:0] mem [MAX_LEN];
  logic [LW-1:0] length, idx, idx_next;
  logic [DW-1:0] div, div_nxt;
  logic [TW-1:0] tick, tick_nxt;
  logic          prev_zero, div_last, on_done, off_done, btn_onehot, mem_we;
  logic [NW-1:0] btn_idx, sample;
  logic [NW:0]   s_ext;

  always_comb begin
    btn_onehot = (btns != '0) && ((btns & (btns - NUM_BTNS'(1))) == '0);
    btn_idx = '0;
    for (int i = 0; i < NUM_BTNS; i++)
      if (btns[i]) btn_idx = NW'(i);
    // Fold out-of-range LFSR samples back into the channel range.
    s_ext    = {1'b0, lfsr[NW-1:0]};
    sample   = (s_ext >= NB_EXT) ? NW'(s_ext - NB_EXT) : lfsr[NW-1:0];
    idx_next = idx + LW'(1);
    div_last = (div == DIV_LAST);
    div_nxt  = div_last ? '0 : div + DW'(1);
    tick_nxt = div_last ? tick + TW'(1) : tick;
    on_done  = div_last && (tick == ON_LAST);
    off_done = div_last && (tick == OFF_LAST);
    mem_we   = !reset && (state == S_ADD) && (length < MAX_LEN_V);
  end

  assign leds = pressed ? (NUM_BTNS'(1) << num) : '0;

  always_ff @(posedge clk) begin
    if (mem_we) mem[length[AW-1:0]] <= sample;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_ADD;
      lfsr       <= LFSR_SEED;
      length     <= '0;
      idx        <= '0;
      div        <= '0;
      tick       <= '0;
      prev_zero  <= 1'b0;
      simon_turn <= 1'b0;
      num        <= '0;
      pressed    <= 1'b0;
      game_over  <= 1'b0;
      win        <= 1'b0;
      score      <= '0;
    end else begin
      lfsr      <= lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);
      prev_zero <= (btns == '0);
      case (state)
        S_ADD: begin
          length     <= length + LW'(1);
          idx        <= '0;
          div        <= '0;
          tick       <= '0;
          simon_turn <= 1'b1;
          pressed    <= 1'b1;
          num        <= (length == '0) ? sample : mem[0];
          state      <= S_PLAY_ON;
        end
        S_PLAY_ON: begin
          if (on_done) begin
            div     <= '0;
            tick    <= '0;
            pressed <= 1'b0;
            state   <= S_PLAY_OFF;
          end else begin
            div  <= div_nxt;
            tick <= tick_nxt;
          end
        end
        S_PLAY_OFF: begin
          if (off_done) begin
            div  <= '0;
            tick <= '0;
            if (idx_next == length) begin
              idx        <= '0;
              simon_turn <= 1'b0;
              state      <= S_WAIT_IN;
            end else begin
              idx     <= idx_next;
              num     <= mem[idx_next[AW-1:0]];
              pressed <= 1'b1;
              state   <= S_PLAY_ON;
            end
          end else begin
            div  <= div_nxt;
            tick <= tick_nxt;
          end
        end
        S_WAIT_IN: begin
          pressed <= btn_onehot;
          if (btn_onehot) num <= btn_idx;
          // Only a fresh press (previous cycle all-zero) is compared.
          if (btn_onehot && prev_zero) begin
            div  <= '0;
            tick <= '0;
            if (btn_idx == mem[idx[AW-1:0]]) begin
              state <= S_WAIT_REL;
            end else begin
              game_over <= 1'b1;
              pressed   <= 1'b0;
              state     <= S_OVER;
            end
`ifdef SIMON_TIMEOUT_EN
          end else if (div_last && (tick == TO_LAST)) begin
            div       <= '0;
            tick      <= '0;
            game_over <= 1'b1;
            pressed   <= 1'b0;
            state     <= S_OVER;
          end else begin
            div  <= div_nxt;
            tick <= tick_nxt;
          end
`else
          end
`endif
        end
        S_WAIT_REL: begin
          if (btns == '0) begin
            pressed <= 1'b0;
            if (idx_next == length) begin
              idx   <= '0;
              score <= length;
              if (length == MAX_LEN_V) begin
                win   <= 1'b1;
                state <= S_WIN;
              end else begin
                state <= S_GAP;
              end
            end else begin
              idx   <= idx_next;
              state <= S_WAIT_IN;
            end
          end
        end
        S_GAP: begin
          if (off_done) begin
            div   <= '0;
            tick  <= '0;
            state <= S_ADD;
          end else begin
            div  <= div_nxt;
            tick <= tick_nxt;
          end
        end
        S_OVER, S_WIN: begin
          pressed <= 1'b0;
          if (btn_onehot && prev_zero) begin
            length    <= '0;
            idx       <= '0;
            score     <= '0;
            game_over <= 1'b0;
            win       <= 1'b0;
            state     <= S_ADD;
          end
        end
        default: state <= S_ADD;
      endcase
    end
  end

endmodule

// File: tb/tb_simon_engine.sv
// tb/tb_simon_engine.sv - self-checking bench for simon_engine with a sequence/timing reference model.
`timescale 1ns/1ps
module tb_simon_engine;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] btns = '0;
  logic       simon_turn, pressed, game_over, win;
  logic [1:0] num;
  logic [3:0] leds;
  logic [2:0] score;

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;
  int add_edge = 0;
  int seq[$];

  simon_engine #(
    .NUM_BTNS(4), .MAX_LEN(4), .TICK_DIV(4), .ON_TICKS(2), .OFF_TICKS(1),
    .LFSR_SEED(16'hACE1), .TIMEOUT_TICKS(3)
  ) dut (
    .clk(clk), .reset(reset), .btns(btns), .simon_turn(simon_turn), .num(num),
    .pressed(pressed), .leds(leds), .game_over(game_over), .win(win), .score(score)
  );

  always #5 clk = ~clk;

  // Index of the next rising edge the design will see since reset release.
  always @(posedge clk or posedge reset)
    if (reset) edge_cnt <= 0;
    else       edge_cnt <= edge_cnt + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  function automatic int sample_at(int k);
    logic [15:0] x = 16'hACE1;
    int s;
    for (int j = 0; j < k; j++) x = x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
    s = int'(x[1:0]);
    if (s >= 4) s -= 4;
    return s;
  endfunction

  task automatic wait_after(int k);
    while (edge_cnt <= k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic new_round(int e);
    add_edge = e;
    seq.push_back(sample_at(e));
  endtask

  task automatic check_playback(string tag, int hold);
    int n;
    logic ep;
    logic [3:0] el;
    n = seq.size();
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < 12; c++) begin
        wait_after(add_edge + 12 * i + c);
        ep = (c < 8);
        el = ep ? 4'(1 << seq[i]) : 4'b0000;
        checks++;
        if (simon_turn !== 1'b1 || pressed !== ep || leds !== el || (ep && num !== 2'(seq[i]))) begin
          errors++;
          $display("FAIL %s playback step %0d cycle %0d: got simon_turn=%b pressed=%b leds=%b num=%0d, expected simon_turn=1 pressed=%b leds=%b num=%0d",
                   tag, i, c, simon_turn, pressed, leds, num, ep, el, seq[i]);
        end
        if (hold >= 0 && i == 0 && c == 2) btns = 4'(1 << hold);
      end
    end
    wait_after(add_edge + 12 * n);
    checks++;
    if (simon_turn !== 1'b0 || pressed !== 1'b0) begin
      errors++;
      $display("FAIL %s playback end: got simon_turn=%b pressed=%b, expected 0 0", tag, simon_turn, pressed);
    end
  endtask

  task automatic do_press(string tag, int b, output int rel);
    int c;
    int hold;
    repeat ($urandom_range(0, 3)) step();
    btns = 4'(1 << b);
    c = edge_cnt;
    wait_after(c);
    checks++;
    if (pressed !== 1'b1 || num !== 2'(b) || game_over !== 1'b0 || simon_turn !== 1'b0) begin
      errors++;
      $display("FAIL %s accept: got pressed=%b num=%0d game_over=%b simon_turn=%b, expected 1 %0d 0 0",
               tag, pressed, num, game_over, simon_turn, b);
    end
    hold = $urandom_range(1, 4);
    for (int h = 1; h < hold; h++) begin
      wait_after(c + h);
      checks++;
      if (pressed !== 1'b1 || leds !== 4'(1 << b)) begin
        errors++;
        $display("FAIL %s hold: got pressed=%b leds=%b, expected 1 %b", tag, pressed, leds, 4'(1 << b));
      end
    end
    btns = '0;
    rel = edge_cnt;
    wait_after(rel);
    checks++;
    if (pressed !== 1'b0) begin
      errors++;
      $display("FAIL %s release: got pressed=%b, expected 0", tag, pressed);
    end
  endtask

  task automatic finish_round(string tag);
    int rel;
    foreach (seq[i]) do_press(tag, seq[i], rel);
    checks++;
    if (score !== 3'(seq.size())) begin
      errors++;
      $display("FAIL %s score: got %0d, expected %0d", tag, score, seq.size());
    end
    if (seq.size() == 4) begin
      checks++;
      if (win !== 1'b1) begin
        errors++;
        $display("FAIL %s win: got %b, expected 1", tag, win);
      end
    end else begin
      for (int c = 0; c < 5; c++) begin
        wait_after(rel + c);
        checks++;
        if (simon_turn !== 1'b0 || pressed !== 1'b0 || win !== 1'b0) begin
          errors++;
          $display("FAIL %s gap cycle %0d: got simon_turn=%b pressed=%b win=%b, expected 0 0 0",
                   tag, c, simon_turn, pressed, win);
        end
      end
      new_round(rel + 5);
    end
  endtask

  task automatic restart_press(string tag);
    int p;
    btns = 4'(1 << $urandom_range(0, 3));
    p = edge_cnt;
    wait_after(p);
    checks++;
    if (game_over !== 1'b0 || win !== 1'b0 || score !== 3'd0 || simon_turn !== 1'b0) begin
      errors++;
      $display("FAIL %s restart: got game_over=%b win=%b score=%0d simon_turn=%b, expected 0 0 0 0",
               tag, game_over, win, score, simon_turn);
    end
    btns = '0;
    seq.delete();
    new_round(p + 1);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    checks++;
    if (simon_turn !== 1'b0 || num !== 2'd0 || pressed !== 1'b0 || leds !== 4'd0 ||
        game_over !== 1'b0 || win !== 1'b0 || score !== 3'd0) begin
      errors++;
      $display("FAIL reset: got simon_turn=%b num=%0d pressed=%b leds=%b game_over=%b win=%b score=%0d, expected all 0",
               simon_turn, num, pressed, leds, game_over, win, score);
    end
    reset = 1'b0;
    seq.delete();
    new_round(0);
  endtask

  task automatic test_first_round();
    check_playback("round1", -1);
    finish_round("round1");
  endtask

  task automatic test_wrong_press();
    int wb, c;
    check_playback("round2", -1);
    wb = (seq[0] + int'($urandom_range(1, 3))) % 4;
    btns = 4'(1 << wb);
    c = edge_cnt;
    wait_after(c);
    checks++;
    if (game_over !== 1'b1 || pressed !== 1'b0 || score !== 3'd1) begin
      errors++;
      $display("FAIL wrong_press: got game_over=%b pressed=%b score=%0d, expected 1 0 1", game_over, pressed, score);
    end
    btns = 4'(1 << ((wb + 1) % 4));
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (game_over !== 1'b1 || simon_turn !== 1'b0 || pressed !== 1'b0) begin
        errors++;
        $display("FAIL over_hold: got game_over=%b simon_turn=%b pressed=%b, expected 1 0 0",
                 game_over, simon_turn, pressed);
      end
    end
    btns = '0;
    step();
    step();
    restart_press("over");
  endtask

  task automatic test_multi_bit();
    check_playback("multi", -1);
    btns = 4'b0011;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (pressed !== 1'b0 || game_over !== 1'b0 || simon_turn !== 1'b0 || score !== 3'd0) begin
        errors++;
        $display("FAIL multi_bit: got pressed=%b game_over=%b simon_turn=%b score=%0d, expected 0 0 0 0",
                 pressed, game_over, simon_turn, score);
      end
    end
    btns = '0;
    step();
    finish_round("multi");
  endtask

  task automatic test_held_press();
    int h;
    h = int'($urandom_range(0, 3));
    check_playback("held", h);
    for (int k = 0; k < 2; k++) begin
      step();
      checks++;
      if (pressed !== 1'b1 || num !== 2'(h) || leds !== 4'(1 << h) || simon_turn !== 1'b0 || game_over !== 1'b0) begin
        errors++;
        $display("FAIL held_mirror: got pressed=%b num=%0d leds=%b simon_turn=%b game_over=%b, expected 1 %0d %b 0 0",
                 pressed, num, leds, simon_turn, game_over, h, 4'(1 << h));
      end
    end
    btns = '0;
    step();
    checks++;
    if (pressed !== 1'b0 || game_over !== 1'b0 || score !== 3'd1) begin
      errors++;
      $display("FAIL held_release: got pressed=%b game_over=%b score=%0d, expected 0 0 1", pressed, game_over, score);
    end
    finish_round("held");
  endtask

  task automatic test_win();
    check_playback("round3", -1);
    finish_round("round3");
    check_playback("round4", -1);
    finish_round("round4");
    step();
    restart_press("win");
  endtask

  task automatic test_reset_mid_playback();
    check_playback("g3r1", -1);
    finish_round("g3r1");
    check_playback("g3r2", -1);
    finish_round("g3r2");
    wait_after(add_edge + 5);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (simon_turn !== 1'b0 || num !== 2'd0 || pressed !== 1'b0 || leds !== 4'd0 ||
        game_over !== 1'b0 || win !== 1'b0 || score !== 3'd0) begin
      errors++;
      $display("FAIL mid_reset: got simon_turn=%b num=%0d pressed=%b leds=%b game_over=%b win=%b score=%0d, expected all 0",
               simon_turn, num, pressed, leds, game_over, win, score);
    end
    step();
    step();
    reset = 1'b0;
    seq.delete();
    new_round(0);
    check_playback("after_reset", -1);
  endtask

  task automatic test_timeout();
    int e;
    e = add_edge + 12 * seq.size();
`ifdef SIMON_TIMEOUT_EN
    wait_after(e + 11);
    checks++;
    if (game_over !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early: got game_over=%b, expected 0", game_over);
    end
    wait_after(e + 12);
    checks++;
    if (game_over !== 1'b1 || pressed !== 1'b0) begin
      errors++;
      $display("FAIL timeout: got game_over=%b pressed=%b, expected 1 0", game_over, pressed);
    end
`else
    wait_after(e + 1000);
    checks++;
    if (game_over !== 1'b0 || simon_turn !== 1'b0 || win !== 1'b0) begin
      errors++;
      $display("FAIL no_timeout: got game_over=%b simon_turn=%b win=%b, expected 0 0 0", game_over, simon_turn, win);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_first_round();
    test_wrong_press();
    test_multi_bit();
    test_held_press();
    test_win();
    test_reset_mid_playback();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
